alu_log_ctrl: RTL and testbench
===============================

ALU_LOG_CTRL -- requirements
Module: alu_log_ctrl

Interface
REQ-001 Parameter DATA_W, default 29, record width (8+8+3+8+1+1 result record).
REQ-002 Parameter ADDR_W, default 5, log address width; depth = 2**ADDR_W = 32.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_req  input  1  ALU requests to log a record.
REQ-006 wr_data  input  DATA_W  record to log.
REQ-007 wr_ready  output  1  write accepted this cycle when wr_req && wr_ready.
REQ-008 rd_req  input  1  host random-read request.
REQ-009 rd_addr  input  ADDR_W  host read index.
REQ-010 rd_ready  output  1  read accepted this cycle when rd_req && rd_ready.
REQ-011 rd_valid  output  1  one-cycle pulse, read response present.
REQ-012 rd_data  output  DATA_W  read response data.
REQ-013 rd_err  output  1  qualifies rd_valid; index not yet written.
REQ-014 dump_start  input  1  start sequential dump of all logged entries.
REQ-015 dump_valid, dump_last  output  1 each  dump beat strobe; final beat flag.
REQ-016 dump_data  output  DATA_W  dump beat data.
REQ-017 clr  input  1  empty the log.
REQ-018 busy  output  1  high in DUMP or CLEAR state.
REQ-019 count  output  ADDR_W+1  entries logged, 0..32.
REQ-020 full  output  1  count == 32.
REQ-021 mem_data_in  output  DATA_W, mem_write_en  output  1  log memory write port.
REQ-022 mem_read_addr  output  ADDR_W, mem_read_addr_en  output  1  log memory read port.
REQ-023 mem_data_out  input  DATA_W  log memory combinational read data.
REQ-024 mem_rst  output  1  active-low reset to log memory.

Function
REQ-025 States: IDLE, DUMP, CLEAR; one write or one read of the memory per cycle.
REQ-026 Priority in IDLE: clr > dump_start (count>0) > write/read arbitration.
REQ-027 clr in IDLE: mem_rst low that cycle, count <= 0 at the edge, next state CLEAR for one cycle (mem_rst low), then IDLE.
REQ-028 dump_start in IDLE with count==0 ignored; with count>0 enter DUMP, dump index <= 0.
REQ-029 DUMP: mem_read_addr_en=1, mem_read_addr=index; dump_data registered from mem_data_out; dump_valid one cycle after each read; index increments each cycle.
REQ-030 DUMP: dump_last with beat for index count-1; return to IDLE on the cycle that beat is output; dump of N entries takes N+1 cycles in DUMP.
REQ-031 wr_ready = IDLE && !full && no clr/dump_start && arbitration grant to writer.
REQ-032 rd_ready = IDLE && no clr/dump_start && arbitration grant to reader; reads served when full.
REQ-033 Both wr_req and rd_req eligible: round-robin, grant opposite of last grant; single requester always granted; last_grant updates only on accepted transfer.
REQ-034 Accepted write: mem_write_en=1, mem_data_in=wr_data same cycle (combinational); count+1 at edge.
REQ-035 Accepted read: mem_read_addr_en=1, mem_read_addr=rd_addr; next cycle rd_valid=1, rd_data=mem_data_out captured, rd_err=(rd_addr>=count); rd_err forces rd_data=0.
REQ-036 count saturates at 32; no write when full (memory pointer never wraps).
REQ-037 Outside granted reads/dump, mem_read_addr_en=0, mem_read_addr=0; mem_write_en=0 except accepted write.
REQ-038 wr_req/rd_req held by requester until accepted; no request queued internally.
REQ-039 dump_start, rd_req, wr_req ignored while busy; clr ignored in DUMP.

Reset
REQ-040 rst=1 at a clock edge: state IDLE, count=0, full=0, last_grant=read, rd_valid=rd_err=dump_valid=dump_last=0, rd_data=dump_data=0, index=0.
REQ-041 mem_rst=0 whenever rst=1 (combinational) and in CLEAR; else 1.
REQ-042 rst mid-DUMP aborts dump: no further dump_valid, log emptied.

Verification
REQ-043 Reset, write 3 records A,B,C back-to-back -> wr_ready each cycle, count=3, mem_write_en 3 cycles.
REQ-044 wr_req and rd_req(addr 0) both held from reset -> write granted first, read next cycle, rd_valid with rd_data=record written at 0 after write completes ordering.
REQ-045 32 writes then wr_req -> full=1, wr_ready=0; rd_req addr 31 still served, rd_err=0.
REQ-046 count=3, dump_start -> dump_valid 3 consecutive cycles with A,B,C, dump_last on C, busy 4 cycles, wr_ready=0 throughout.
REQ-047 count=2, rd_req addr 5 -> rd_valid=1, rd_err=1, rd_data=0.
REQ-048 count=3, clr -> mem_rst low 2 cycles, count=0; subsequent dump_start ignored, busy stays 0.

Source files
------------

// File: rtl/alu_log_ctrl.sv
// Result-record log: ALU appends records, host reads by index or dumps the whole log.
// The external memory owns its write pointer; mem_rst rewinds it.
module alu_log_ctrl #(
    parameter int unsigned DATA_W = 29,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    input  logic              dump_start,
    output logic              dump_valid,
    output logic              dump_last,
    output logic [DATA_W-1:0] dump_data,
    input  logic              clr,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic              mem_read_addr_en,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_rst
);

    typedef enum logic [1:0] {StIdle, StDump, StClear} state_e;

    localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_idx;
    logic                r_last_rd;
    logic                r_rd_valid;
    logic                r_rd_err;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_dump_valid;
    logic                r_dump_last;
    logic [DATA_W-1:0]   r_dump_data;

    logic w_idle, w_full, w_clr_go, w_dump_go, w_arb_ok;
    logic w_wr_elig, w_rd_elig, w_wr_go, w_rd_go, w_rd_oob;
    logic w_dump_rd, w_dump_last_rd;

    always_comb begin
        w_idle    = (r_state == StIdle);
        w_full    = (r_count == Depth);
        w_clr_go  = w_idle && clr;
        w_dump_go = w_idle && !clr && dump_start && (r_count != '0);
        w_arb_ok  = w_idle && !clr && !w_dump_go;
        w_wr_elig = w_arb_ok && wr_req && !w_full;
        w_rd_elig = w_arb_ok && rd_req;
        // Contention goes to whoever was not granted last.
        w_wr_go   = w_wr_elig && (!w_rd_elig || r_last_rd);
        w_rd_go   = w_rd_elig && (!w_wr_elig || !r_last_rd);
        w_rd_oob  = ({1'b0, rd_addr} >= r_count);
        w_dump_rd      = (r_state == StDump) && (r_idx < r_count);
        w_dump_last_rd = w_dump_rd && (r_idx == r_count - 1'b1);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_clr_go) begin
                    w_state_nxt = StClear;
                end else if (w_dump_go) begin
                    w_state_nxt = StDump;
                end
            end
            StDump:  if (r_dump_last) w_state_nxt = StIdle;
            StClear: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        mem_write_en     = w_wr_go;
        mem_data_in      = w_wr_go ? wr_data : '0;
        mem_read_addr_en = w_rd_go || w_dump_rd;
        mem_read_addr    = '0;
        if (w_rd_go) begin
            mem_read_addr = rd_addr;
        end else if (w_dump_rd) begin
            mem_read_addr = r_idx[ADDR_W-1:0];
        end
        mem_rst = !(rst || w_clr_go || (r_state == StClear));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_idx        <= '0;
            r_last_rd    <= 1'b1;
            r_rd_valid   <= 1'b0;
            r_rd_err     <= 1'b0;
            r_rd_data    <= '0;
            r_dump_valid <= 1'b0;
            r_dump_last  <= 1'b0;
            r_dump_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr_go) begin
                r_count <= '0;
            end else if (w_wr_go) begin
                r_count <= r_count + 1'b1;
            end
            if (w_wr_go) begin
                r_last_rd <= 1'b0;
            end else if (w_rd_go) begin
                r_last_rd <= 1'b1;
            end
            r_rd_valid <= w_rd_go;
            r_rd_err   <= w_rd_go && w_rd_oob;
            if (w_rd_go) begin
                r_rd_data <= w_rd_oob ? '0 : mem_data_out;
            end
            if (w_dump_go) begin
                r_idx <= '0;
            end else if (w_dump_rd) begin
                r_idx <= r_idx + 1'b1;
            end
            r_dump_valid <= w_dump_rd;
            r_dump_last  <= w_dump_last_rd;
            if (w_dump_rd) begin
                r_dump_data <= mem_data_out;
            end
        end
    end

    assign wr_ready   = w_wr_go;
    assign rd_ready   = w_rd_go;
    assign rd_valid   = r_rd_valid;
    assign rd_err     = r_rd_err;
    assign rd_data    = r_rd_data;
    assign dump_valid = r_dump_valid;
    assign dump_last  = r_dump_last;
    assign dump_data  = r_dump_data;
    assign busy       = (r_state != StIdle);
    assign count      = r_count;
    assign full       = w_full;

endmodule

// File: tb/tb_alu_log_ctrl.sv
// Scoreboard bench for alu_log_ctrl with a behavioural pointer-based log memory.
module tb_alu_log_ctrl;

    localparam int DW = 29;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          flag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, rd_req, dump_start, clr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          wr_ready, rd_ready, rd_valid, rd_err, dump_valid, dump_last, busy, full;
    logic [DW-1:0] rd_data, dump_data, mem_data_in, mem_data_out;
    logic [AW:0]   count;
    logic          mem_write_en, mem_read_addr_en, mem_rst;
    logic [AW-1:0] mem_read_addr;

    logic [DW-1:0] mem [32];
    int            wptr;
    exp_t          rd_q[$];
    exp_t          dump_q[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] vals [32];

    localparam logic [DW-1:0] RecA = 29'h0ABC_DE1;
    localparam logic [DW-1:0] RecB = 29'h1234_567;
    localparam logic [DW-1:0] RecC = 29'h1F0F_0F0;
    localparam logic [DW-1:0] RecD = 29'h0555_AAA;

    always #5 clk = ~clk;

    alu_log_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_last(dump_last),
        .dump_data(dump_data), .clr(clr), .busy(busy), .count(count), .full(full),
        .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_read_addr(mem_read_addr), .mem_read_addr_en(mem_read_addr_en),
        .mem_data_out(mem_data_out), .mem_rst(mem_rst)
    );

    // Memory appends at its own pointer; mem_rst low rewinds it.
    always @(posedge clk) begin
        if (!mem_rst) begin
            wptr <= 0;
        end else if (mem_write_en && wptr < 32) begin
            mem[wptr] <= mem_data_in;
            wptr <= wptr + 1;
        end
    end
    assign mem_data_out = mem[mem_read_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e.data));
                check("rd_err", 32'(rd_err), 32'(e.flag));
            end
        end
        if (dump_valid) begin
            if (dump_q.size() == 0) begin
                check("dump_unexpected", 32'd1, 32'd0);
            end else begin
                e = dump_q.pop_front();
                check("dump_data", 32'(dump_data), 32'(e.data));
                check("dump_last", 32'(dump_last), 32'(e.flag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("mem_rst_in_reset", 32'(mem_rst), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int nbusy;
        rst = 1'b1; wr_req = 0; rd_req = 0; dump_start = 0; clr = 0;
        wr_data = '0; rd_addr = '0;
        tick();
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_mem_rst", 32'(mem_rst), 32'd1);

        // Three back-to-back writes, then dump, then clear.
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1;
            wr_data = (i == 0) ? RecA : (i == 1) ? RecB : RecC;
            #1;
            check("wr_ready_abc", 32'(wr_ready), 32'd1);
            check("mem_we_abc", 32'(mem_write_en), 32'd1);
            check("mem_din_abc", 32'(mem_data_in), 32'(wr_data));
            tick();
        end
        wr_req = 1'b0;
        #1;
        check("count_3", 32'(count), 32'd3);
        dump_q.push_back('{data: RecA, flag: 1'b0});
        dump_q.push_back('{data: RecB, flag: 1'b0});
        dump_q.push_back('{data: RecC, flag: 1'b1});
        dump_start = 1'b1; wr_req = 1'b1; wr_data = RecD;
        #1;
        check("wr_ready_dump_start", 32'(wr_ready), 32'd0);
        tick();
        dump_start = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 12 && busy; k++) begin
            check("wr_ready_in_dump", 32'(wr_ready), 32'd0);
            nbusy++;
            tick();
        end
        wr_req = 1'b0;
        #1;
        check("dump_busy_cycles", 32'(nbusy), 32'd4);
        check("dump_q_drained", 32'(dump_q.size()), 32'd0);
        check("count_after_dump", 32'(count), 32'd3);
        clr = 1'b1;
        #1;
        check("mem_rst_clr_cycle", 32'(mem_rst), 32'd0);
        tick();
        clr = 1'b0;
        #1;
        check("mem_rst_clear_state", 32'(mem_rst), 32'd0);
        check("busy_clear_state", 32'(busy), 32'd1);
        check("count_cleared", 32'(count), 32'd0);
        tick();
        check("mem_rst_after_clear", 32'(mem_rst), 32'd1);
        check("busy_after_clear", 32'(busy), 32'd0);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("busy_empty_dump", 32'(busy), 32'd0);
        tick();
        check("busy_empty_dump2", 32'(busy), 32'd0);

        // Write and read held from reset: write first, then read, then next write.
        wr_req = 1'b1; wr_data = RecA; rd_req = 1'b1; rd_addr = '0;
        do_reset();
        check("rr_wr_first", 32'(wr_ready), 32'd1);
        check("rr_rd_wait", 32'(rd_ready), 32'd0);
        check("rr_mem_din", 32'(mem_data_in), 32'(RecA));
        tick();
        wr_data = RecB;
        #1;
        check("rr_wr_second", 32'(wr_ready), 32'd0);
        check("rr_rd_second", 32'(rd_ready), 32'd1);
        check("rr_rd_addr", 32'(mem_read_addr), 32'd0);
        rd_q.push_back('{data: RecA, flag: 1'b0});
        tick();
        rd_req = 1'b0;
        #1;
        check("rr_wr_third", 32'(wr_ready), 32'd1);
        tick();
        wr_req = 1'b0;
        #1;
        check("count_2", 32'(count), 32'd2);
        rd_req = 1'b1; rd_addr = 5'd5;
        #1;
        check("rd_ready_oob", 32'(rd_ready), 32'd1);
        rd_q.push_back('{data: '0, flag: 1'b1});
        tick();
        rd_addr = 5'd1;
        rd_q.push_back('{data: RecB, flag: 1'b0});
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("idle_mem_re", 32'(mem_read_addr_en), 32'd0);

        // Fill to 32, then read while full, then reset in the middle of a dump.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            vals[i] = DW'(i * 7 + 3);
            wr_req = 1'b1; wr_data = vals[i];
            tick();
        end
        wr_data = RecD; rd_req = 1'b1; rd_addr = 5'd31;
        #1;
        check("count_32", 32'(count), 32'd32);
        check("full_32", 32'(full), 32'd1);
        check("wr_ready_full", 32'(wr_ready), 32'd0);
        check("rd_ready_full", 32'(rd_ready), 32'd1);
        rd_q.push_back('{data: vals[31], flag: 1'b0});
        tick();
        rd_req = 1'b0;
        #1;
        check("wr_ready_full2", 32'(wr_ready), 32'd0);
        check("count_sat", 32'(count), 32'd32);
        wr_req = 1'b0;
        tick();
        tick();
        dump_q.push_back('{data: vals[0], flag: 1'b0});
        dump_q.push_back('{data: vals[1], flag: 1'b0});
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_count", 32'(count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_full", 32'(full), 32'd0);
        tick();
        tick();
        check("final_rd_q", 32'(rd_q.size()), 32'd0);
        check("final_dump_q", 32'(dump_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
